// File: rtl/viewport_pkg.sv
// Shared types and helpers for the frame buffer viewport.
// Scale codes map to a left shift of the stored image size.
package viewport_pkg;

    typedef enum logic [1:0] {
        SCALE_1    = 2'd0,
        SCALE_2    = 2'd1,
        SCALE_4    = 2'd2,
        SCALE_RSVD = 2'd3
    } scale_t;

    function automatic int latency(input int ram_latency);
        return 3 + ram_latency;
    endfunction

    // Reserved code behaves as x1.
    function automatic logic [1:0] scale_shift(input scale_t s);
        case (s)
            SCALE_2: return 2'd1;
            SCALE_4: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Generic fixed-depth shift-register delay, cleared by async reset.
module pipe_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/framebuffer_viewport.sv
// Read-side viewport: raster position -> frame buffer address, pixel/background
// select, and raster sideband delayed to line up with the returned pixel.
module framebuffer_viewport
    import viewport_pkg::*;
#(
    parameter int              H_BITS      = 11,
    parameter int              V_BITS      = 10,
    parameter int              IMG_W       = 240,
    parameter int              IMG_H       = 320,
    parameter int              ADDR_W      = 17,
    parameter int              PIX_W       = 16,
    parameter int              RAM_LATENCY = 2,
    parameter int              X0_RST      = 200,
    parameter int              Y0_RST      = 250,
    parameter logic [PIX_W-1:0] BG_PIXEL   = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [H_BITS-1:0] hcount_in,
    input  logic [V_BITS-1:0] vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              blank_in,
    input  logic [H_BITS-1:0] x0_in,
    input  logic [V_BITS-1:0] y0_in,
    input  logic [1:0]        scale_in,
    input  logic              mirror_in,
    input  logic              cfg_valid_in,
    output logic              cfg_pending_out,
    output logic [ADDR_W-1:0] addr_out,
    input  logic [PIX_W-1:0]  ram_data_in,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              in_window_out,
    output logic [H_BITS-1:0] hcount_out,
    output logic [V_BITS-1:0] vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              blank_out
);

    localparam int LAT = latency(RAM_LATENCY);
    localparam int BW  = H_BITS + V_BITS + 4;

    logic [H_BITS-1:0] x0_act, x0_shd, x0_eff;
    logic [V_BITS-1:0] y0_act, y0_shd, y0_eff;
    scale_t            s_act, s_shd, s_eff;
    logic              mir_act, mir_shd, mir_eff;
    logic              frame_start;

    assign frame_start = (hcount_in == '0) && (vcount_in == '0);

    // The frame-start pixel already sees the config being loaded on that cycle.
    always_comb begin
        x0_eff  = x0_act;
        y0_eff  = y0_act;
        s_eff   = s_act;
        mir_eff = mir_act;
        if (frame_start && cfg_valid_in) begin
            x0_eff  = x0_in;
            y0_eff  = y0_in;
            s_eff   = scale_t'(scale_in);
            mir_eff = mirror_in;
        end else if (frame_start && cfg_pending_out) begin
            x0_eff  = x0_shd;
            y0_eff  = y0_shd;
            s_eff   = s_shd;
            mir_eff = mir_shd;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x0_act          <= H_BITS'(X0_RST);
            y0_act          <= V_BITS'(Y0_RST);
            s_act           <= SCALE_1;
            mir_act         <= 1'b0;
            x0_shd          <= H_BITS'(X0_RST);
            y0_shd          <= V_BITS'(Y0_RST);
            s_shd           <= SCALE_1;
            mir_shd         <= 1'b0;
            cfg_pending_out <= 1'b0;
        end else if (frame_start) begin
            x0_act          <= x0_eff;
            y0_act          <= y0_eff;
            s_act           <= s_eff;
            mir_act         <= mir_eff;
            cfg_pending_out <= 1'b0;
        end else if (cfg_valid_in) begin
            x0_shd          <= x0_in;
            y0_shd          <= y0_in;
            s_shd           <= scale_t'(scale_in);
            mir_shd         <= mirror_in;
            cfg_pending_out <= 1'b1;
        end
    end

    // Stage 1: window-relative position and window test.
    logic signed [H_BITS:0] rx_c, rx_q;
    logic signed [V_BITS:0] ry_c, ry_q;
    logic [1:0]             sh_c, sh_q;
    logic                   in_win_c, in_win_q, mir_q;

    assign rx_c     = $signed({1'b0, hcount_in}) - $signed({1'b0, x0_eff});
    assign ry_c     = $signed({1'b0, vcount_in}) - $signed({1'b0, y0_eff});
    assign sh_c     = scale_shift(s_eff);
    assign in_win_c = !rx_c[H_BITS] && (int'(rx_c) < (IMG_W << sh_c)) &&
                      !ry_c[V_BITS] && (int'(ry_c) < (IMG_H << sh_c));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_q     <= '0;
            ry_q     <= '0;
            sh_q     <= '0;
            mir_q    <= 1'b0;
            in_win_q <= 1'b0;
        end else begin
            rx_q     <= rx_c;
            ry_q     <= ry_c;
            sh_q     <= sh_c;
            mir_q    <= mir_eff;
            in_win_q <= in_win_c;
        end
    end

    // Stage 2: image coordinates -> linear address.
    logic [ADDR_W-1:0] col_c, row_c, addr_c;

    always_comb begin
        col_c = ADDR_W'(rx_q[H_BITS-1:0] >> sh_q);
        row_c = ADDR_W'(ry_q[V_BITS-1:0] >> sh_q);
        if (mir_q) col_c = ADDR_W'(IMG_W - 1) - col_c;
        addr_c = in_win_q ? (row_c * ADDR_W'(IMG_W) + col_c) : '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) addr_out <= '0;
        else        addr_out <= addr_c;
    end

    // Sideband rides alongside; the final output register adds the last cycle.
    logic [BW-1:0]     bundle_d;
    logic [H_BITS-1:0] h_d;
    logic [V_BITS-1:0] v_d;
    logic              hs_d, vs_d, bl_d, inw_d;

    pipe_delay #(.WIDTH(BW), .DEPTH(LAT - 1)) u_side_dly (
        .clk  (clk_in),
        .rst  (rst_in),
        .din  ({hcount_in, vcount_in, hsync_in, vsync_in, blank_in, in_win_c}),
        .dout (bundle_d)
    );

    assign {h_d, v_d, hs_d, vs_d, bl_d, inw_d} = bundle_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pixel_out     <= '0;
            in_window_out <= 1'b0;
            hcount_out    <= '0;
            vcount_out    <= '0;
            hsync_out     <= 1'b0;
            vsync_out     <= 1'b0;
            blank_out     <= 1'b0;
        end else begin
            pixel_out     <= inw_d ? ram_data_in : BG_PIXEL;
            in_window_out <= inw_d;
            hcount_out    <= h_d;
            vcount_out    <= v_d;
            hsync_out     <= hs_d;
            vsync_out     <= vs_d;
            blank_out     <= bl_d;
        end
    end

endmodule

// File: doc/framebuffer_viewport.md
# framebuffer_viewport

Parametrised read-side controller that places a camera frame buffer image on the VGA raster. From the raster counters it generates the frame buffer BRAM read address for a programmable window position, integer scale (×1/×2/×4) and horizontal mirror. It returns the pixel, or a background value outside the window, with hsync/vsync/blank/hcount/vcount delayed to match. It sits between the VGA timing generator and the 65 MHz read port of the frame buffer. It replaces hard-coded offsets and hand-built per-signal pipelines.

## Interface
Parameters:
- H_BITS, 11, hcount width
- V_BITS, 10, vcount width
- IMG_W, 240, stored image width (pixels)
- IMG_H, 320, stored image height (lines)
- ADDR_W, 17, BRAM address width; must satisfy IMG_W*IMG_H ≤ 2^ADDR_W
- PIX_W, 16, pixel width
- RAM_LATENCY, 2, BRAM read latency in cycles (≥1)
- X0_RST, 200, window x origin after reset
- Y0_RST, 250, window y origin after reset
- BG_PIXEL, 0, pixel value driven outside the window

Ports (one clock domain; reset is asynchronous and active-high):
- clk_in  in  1  pixel clock (65 MHz)
- rst_in  in  1  asynchronous, active-high reset
- hcount_in  in  H_BITS  raster x
- vcount_in  in  V_BITS  raster y
- hsync_in, vsync_in, blank_in  in  1 each  raster sideband
- x0_in  in  H_BITS  requested window x origin
- y0_in  in  V_BITS  requested window y origin
- scale_in  in  2  0=×1, 1=×2, 2=×4, 3=reserved (treated as ×1)
- mirror_in  in  1  horizontal mirror
- cfg_valid_in  in  1  single-cycle request to load x0/y0/scale/mirror
- cfg_pending_out  out  1  request captured, not yet applied
- addr_out  out  ADDR_W  BRAM read address
- ram_data_in  in  PIX_W  BRAM read data
- pixel_out  out  PIX_W  final pixel
- in_window_out  out  1  pixel_out came from the image
- hcount_out, vcount_out  out  H_BITS/V_BITS  delayed raster counters
- hsync_out, vsync_out, blank_out  out  1 each  delayed sideband

## Operation
- Active config (x0, y0, s, mirror) changes only on the frame-start cycle (hcount_in==0 && vcount_in==0).
- cfg_valid_in writes the shadow registers and sets cfg_pending_out. A second request while pending overwrites the shadow.
- On the frame-start cycle, active config is loaded from the shadow if pending, and cfg_pending_out clears.
- If cfg_valid_in coincides with frame start, the inputs load active config directly and pending stays 0. The (0,0) pixel uses the new config.
- Window arithmetic uses signed width H_BITS+1 / V_BITS+1:
  - rx = hcount−x0, ry = vcount−y0
  - in_window = rx≥0 && rx<(IMG_W<<s) && ry≥0 && ry<(IMG_H<<s)
- Address arithmetic:
  - col = rx>>s, row = ry>>s
  - if mirror, col = IMG_W−1−col
  - addr = row*IMG_W+col (constant multiply)
- Outside the window: addr_out = 0, pixel_out = BG_PIXEL, in_window_out = 0.
- Window partially or fully off-raster is legal; it clips silently.

## Timing
- Stage 1 (registered): rx, ry, in_window.
- Stage 2 (registered): addr_out, so addr_out lags hcount_in by 2 cycles.
- ram_data_in is sampled RAM_LATENCY cycles after addr_out.
- pixel_out is registered 1 cycle after that sample.
- Total LAT = 3+RAM_LATENCY. Every *_out raster/sideband signal and in_window_out is delayed exactly LAT cycles.
- Reset values:
  - all outputs 0; cfg_pending_out 0
  - active config = (X0_RST, Y0_RST, ×1, no mirror); shadow equal to active
- Reset mid-frame: pipeline cleared. Outputs are valid LAT cycles after deassertion.

## Structure
- Package viewport_pkg holds:
  - scale_t enum (SCALE_1, SCALE_2, SCALE_4, SCALE_RSVD)
  - function latency(ram_latency) returning 3+ram_latency
- Sub-module pipe_delay #(WIDTH, DEPTH) is a generic shift-register delay with async reset. It carries the {hcount, vcount, hsync, vsync, blank, in_window} bundle.

## Test plan
- Reset, then run one frame with defaults:
  - (hcount,vcount)=(200,250) → addr_out=0 two cycles later
  - (439,250) → addr 239
  - (440,250) → in_window_out=0, pixel_out=BG_PIXEL
- Scale ×2, x0=200, y0=250:
  - (203,251) → addr 1
  - (679,889) → addr 76799
  - (680,250) → out of window
- Mirror=1, ×1: (200,250) → addr 239; (439,251) → addr 240.
- cfg_valid_in at (500,300) mid-frame:
  - cfg_pending_out=1, addresses unchanged for the rest of the frame
  - new config used from the next (0,0); pending clears there
- cfg_valid_in on the frame-start cycle → new config applies at (0,0) itself; pending never set.
- Latency with RAM_LATENCY=2: a model BRAM returns addr as data; hsync_in pulse and pixel_out=addr both appear exactly 5 cycles after the input; async reset mid-frame zeroes all outputs immediately.
